// File: rtl/instruction_prefetch.sv
// instruction_prefetch
//   Instruction fetch stage with a small prefetch queue. It issues sequential
//   reads to a synchronous instruction memory (one-cycle read latency) and
//   buffers the responses in a DEPTH-entry FIFO of {pc, instr} pairs. The
//   queue head goes to decode with a valid/ready handshake. A jump flushes
//   the queue and redirects fetch to {last_pc[hi:6], partial_addr}.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous reset, active low
//   imem_req      memory read request this cycle (combinational on jump)
//   imem_addr     memory read address
//   imem_rdata    memory read data, valid one cycle after imem_req
//   instr_valid   queue head holds an instruction
//   instr_code    head instruction (0 when the queue is empty)
//   instr_pc      address of the head instruction (0 when empty)
//   instr_ready   decode accepts the head this cycle
//   jump          single-cycle redirect request
//   partial_addr  low six bits of the jump target
//   level         queue occupancy
module instruction_prefetch #(
  parameter int                ADDR_W   = 8,
  parameter int                DATA_W   = 8,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [ADDR_W-1:0]          imem_addr,
  input  logic [DATA_W-1:0]          imem_rdata,
  output logic                       instr_valid,
  output logic [DATA_W-1:0]          instr_code,
  output logic [ADDR_W-1:0]          instr_pc,
  input  logic                       instr_ready,
  input  logic                       jump,
  input  logic [5:0]                 partial_addr,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int HI_W  = ADDR_W - 6;

  logic                 run;
  logic [ADDR_W-1:0]    fetch_pc;
  logic [ADDR_W-1:0]    req_pc;
  logic [HI_W-1:0]      last_pc_hi;
  logic                 inflight;
  logic                 drop;

  logic [ADDR_W-1:0]    pc_q   [DEPTH];
  logic [DATA_W-1:0]    code_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [LVL_W-1:0]     count;

  logic [LVL_W:0]       credit_used;
  logic                 push;
  logic                 pop;
  logic [ADDR_W-1:0]    jump_target;

  // Credit counts the response already on its way, so the queue can never
  // be asked to hold more than DEPTH entries.
  assign credit_used = {1'b0, count} + {{LVL_W{1'b0}}, inflight};
  assign imem_req    = run && !jump && (credit_used < (LVL_W+1)'(DEPTH));
  assign imem_addr   = fetch_pc;

  // A response landing in the jump cycle belongs to the old stream; the
  // flush at this edge discards it by not pushing.
  assign push = inflight && !drop && !jump;
  assign pop  = instr_valid && instr_ready && !jump;

  assign jump_target = {last_pc_hi, partial_addr};

  assign instr_valid = (count != '0);
  assign instr_code  = instr_valid ? code_q[rd_ptr] : '0;
  assign instr_pc    = instr_valid ? pc_q[rd_ptr]   : '0;
  assign level       = count;

  // run holds off the first request until the first edge after reset, so
  // fetch starts in cycle 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run        <= 1'b0;
      fetch_pc   <= RESET_PC;
      req_pc     <= RESET_PC;
      inflight   <= 1'b0;
      drop       <= 1'b0;
      last_pc_hi <= RESET_PC[ADDR_W-1:6];
    end else begin
      run      <= 1'b1;
      inflight <= imem_req;
      if (imem_req) begin
        req_pc <= fetch_pc;
      end
      if (jump) begin
        fetch_pc <= jump_target;
        // imem_req is forced low in the jump cycle, so the cycle after a
        // jump never carries a live response; drop guards it regardless.
        drop     <= inflight;
      end else begin
        if (imem_req) begin
          fetch_pc <= fetch_pc + ADDR_W'(1);
        end
        drop <= 1'b0;
      end
      // Only the page bits of the accepted pc feed the jump target.
      if (pop) begin
        last_pc_hi <= instr_pc[ADDR_W-1:6];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= '0;
        code_q[i] <= '0;
      end
    end else if (jump) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        pc_q[wr_ptr]   <= req_pc;
        code_q[wr_ptr] <= imem_rdata;
        wr_ptr         <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_prefetch.sv
module tb_instruction_prefetch;

  logic       clk;
  logic       rst;

  logic       imem_req;
  logic [7:0] imem_addr;
  logic [7:0] imem_rdata;
  logic       instr_valid;
  logic [7:0] instr_code;
  logic [7:0] instr_pc;
  logic       instr_ready;
  logic       jump;
  logic [5:0] partial_addr;
  logic [2:0] level;

  logic       w_imem_req;
  logic [7:0] w_imem_addr;
  logic [7:0] w_imem_rdata;
  logic       w_instr_valid;
  logic [7:0] w_instr_code;
  logic [7:0] w_instr_pc;
  logic       w_instr_ready;
  logic       w_jump;
  logic [5:0] w_partial_addr;
  logic [2:0] w_level;

  int checks   = 0;
  int failures = 0;

  instruction_prefetch #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .RESET_PC(8'h00)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .instr_valid  (instr_valid),
    .instr_code   (instr_code),
    .instr_pc     (instr_pc),
    .instr_ready  (instr_ready),
    .jump         (jump),
    .partial_addr (partial_addr),
    .level        (level)
  );

  instruction_prefetch #(.ADDR_W(8), .DATA_W(8), .DEPTH(4), .RESET_PC(8'hFE)) dut_wrap (
    .clk          (clk),
    .rst          (rst),
    .imem_req     (w_imem_req),
    .imem_addr    (w_imem_addr),
    .imem_rdata   (w_imem_rdata),
    .instr_valid  (w_instr_valid),
    .instr_code   (w_instr_code),
    .instr_pc     (w_instr_pc),
    .instr_ready  (w_instr_ready),
    .jump         (w_jump),
    .partial_addr (w_partial_addr),
    .level        (w_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory holding mem[i] = i ^ 8'hA5.
  initial imem_rdata = 8'h00;
  initial w_imem_rdata = 8'h00;
  always @(posedge clk) begin
    if (imem_req)   imem_rdata   <= imem_addr ^ 8'hA5;
    if (w_imem_req) w_imem_rdata <= w_imem_addr ^ 8'hA5;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // Leaves the bench in cycle 0 (reset released, first edge still ahead).
  task automatic restart(input logic rdy);
    @(negedge clk);
    rst = 1'b0;
    instr_ready = rdy;
    jump = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  initial begin
    rst = 1'b0;
    instr_ready = 1'b1;
    jump = 1'b0;
    partial_addr = 6'h00;
    w_instr_ready = 1'b1;
    w_jump = 1'b0;
    w_partial_addr = 6'h00;

    // Reset / prime
    #3;
    chk("rst_valid", instr_valid, 1'b0);
    chk("rst_level", level, 3'd0);
    chk("rst_req",   imem_req, 1'b0);
    chk("rst_code",  instr_code, 8'h00);
    chk("rst_pc",    instr_pc, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("c0_req", imem_req, 1'b0);
    tick;
    chk("c1_req",  imem_req, 1'b1);
    chk("c1_addr", imem_addr, 8'h00);
    chk("w_c1_addr", w_imem_addr, 8'hFE);
    tick;
    chk("c2_valid", instr_valid, 1'b0);
    tick;
    chk("c3_valid", instr_valid, 1'b1);
    chk("c3_pc",    instr_pc, 8'h00);
    chk("c3_code",  instr_code, 8'hA5);
    chk("w_c3_pc",   w_instr_pc, 8'hFE);
    chk("w_c3_code", w_instr_code, 8'h5B);
    tick;
    chk("c4_pc",   instr_pc, 8'h01);
    chk("c4_code", instr_code, 8'hA4);
    chk("w_c4_pc", w_instr_pc, 8'hFF);
    chk("w_c4_code", w_instr_code, 8'h5A);
    tick;
    chk("c5_pc",   instr_pc, 8'h02);
    chk("w_c5_pc", w_instr_pc, 8'h00);
    chk("w_c5_code", w_instr_code, 8'hA5);
    tick;
    chk("c6_pc",   instr_pc, 8'h03);
    chk("w_c6_pc", w_instr_pc, 8'h01);

    // Backpressure
    restart(1'b0);
    for (int c = 1; c <= 10; c++) begin
      tick;
      if (c == 4) begin
        chk("bp_c4_req",  imem_req, 1'b1);
        chk("bp_c4_addr", imem_addr, 8'h03);
      end
      if (c == 5) begin
        chk("bp_c5_level", level, 3'd3);
        chk("bp_c5_req",   imem_req, 1'b0);
      end
      if (c == 6) begin
        chk("bp_c6_level", level, 3'd4);
        chk("bp_c6_req",   imem_req, 1'b0);
      end
      if (c == 10) begin
        chk("bp_c10_level", level, 3'd4);
        chk("bp_c10_req",   imem_req, 1'b0);
        chk("bp_c10_pc",    instr_pc, 8'h00);
      end
    end
    instr_ready = 1'b1;
    for (int c = 11; c <= 14; c++) begin
      tick;
      chk("bp_drain_valid", instr_valid, 1'b1);
      chk("bp_drain_pc",    instr_pc, 8'(c - 10));
      chk("bp_drain_code",  instr_code, 8'(c - 10) ^ 8'hA5);
      if (c == 11) begin
        chk("bp_c11_req",  imem_req, 1'b1);
        chk("bp_c11_addr", imem_addr, 8'h04);
      end
    end

    // Mid-operation reset with level 3 and a response outstanding
    restart(1'b0);
    repeat (5) tick;
    chk("mr_pre_level", level, 3'd3);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_valid", instr_valid, 1'b0);
    chk("mr_level", level, 3'd0);
    chk("mr_req",   imem_req, 1'b0);
    chk("mr_code",  instr_code, 8'h00);
    chk("mr_pc",    instr_pc, 8'h00);
    @(negedge clk);
    instr_ready = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    #1;
    tick;
    chk("mr_c1_addr", imem_addr, 8'h00);
    chk("mr_c1_req",  imem_req, 1'b1);
    tick;
    chk("mr_c2_valid", instr_valid, 1'b0);
    tick;
    chk("mr_c3_pc",   instr_pc, 8'h00);
    chk("mr_c3_code", instr_code, 8'hA5);

    // Jump flush: 0x45 accepted, jump in the next cycle
    for (int i = 0; i < 200; i++) begin
      if (instr_valid && instr_pc == 8'h46) break;
      tick;
    end
    chk("j1_reach_46", instr_pc, 8'h46);
    jump = 1'b1;
    partial_addr = 6'h12;
    #1;
    chk("j1_T_req", imem_req, 1'b0);
    tick;
    jump = 1'b0;
    #1;
    chk("j1_T1_req",   imem_req, 1'b1);
    chk("j1_T1_addr",  imem_addr, 8'h52);
    chk("j1_T1_valid", instr_valid, 1'b0);
    tick;
    chk("j1_T2_valid", instr_valid, 1'b0);
    tick;
    chk("j1_T3_valid", instr_valid, 1'b1);
    chk("j1_T3_pc",    instr_pc, 8'h52);
    chk("j1_T3_code",  instr_code, 8'hF7);
    tick;
    chk("j1_T4_pc",    instr_pc, 8'h53);

    // Jump coinciding with a handshake: head 0x80 must not become last_pc
    for (int i = 0; i < 200; i++) begin
      if (instr_valid && instr_pc == 8'h80) break;
      tick;
    end
    chk("j2_reach_80", instr_pc, 8'h80);
    jump = 1'b1;
    partial_addr = 6'h01;
    tick;
    jump = 1'b0;
    #1;
    chk("j2_T1_addr",  imem_addr, 8'h41);
    chk("j2_T1_valid", instr_valid, 1'b0);
    tick;
    tick;
    chk("j2_T3_valid", instr_valid, 1'b1);
    chk("j2_T3_pc",    instr_pc, 8'h41);
    chk("j2_T3_code",  instr_code, 8'hE4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
